// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one fixed-latency memory port between the IF stage (fetch) and the
// MEM stage (load/store). Accesses are serialised through IDLE -> ISSUE ->
// WAIT. Each requester gets a registered read-data word, a one-cycle done
// pulse and a combinational stall signal.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : when both requesters are eligible, the one not served last wins
//   undefined : fixed DM-over-IF priority, no pointer register
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   MEM_LAT  cycles from the mem_en cycle to the mem_rdata-valid cycle (1..15)
//
// Ports
//   CLK, Reset_L                  clock, asynchronous active-low reset
//   if_req/if_addr                fetch request (held until if_done)
//   if_rdata/if_done/if_stall     fetch result, done pulse, stall
//   dm_req/dm_we/dm_addr/dm_wdata data request (held until dm_done)
//   dm_rdata/dm_done/dm_stall     load result, done pulse, stall
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Counter value loaded in ISSUE; WAIT with the counter at zero is the
  // cycle in which mem_rdata is valid, so MEM_LAT=1 needs no special path.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0]        state_q,     state_d;
  logic [3:0]        cnt_q,       cnt_d;
  logic              owner_q,     owner_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic              if_done_q,   if_done_d;
  logic              dm_done_q,   dm_done_d;

  logic if_elig_s;
  logic dm_elig_s;
  logic grant_any_s;
  logic grant_dm_s;

  // A requester's req is still held during its own done cycle; mask it so
  // the completed access is not re-issued.
  assign if_elig_s   = if_req & ~if_done_q;
  assign dm_elig_s   = dm_req & ~dm_done_q;
  assign grant_any_s = if_elig_s | dm_elig_s;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_q names the requester preferred on the next collision.
  logic rr_q, rr_d;

  // Grant selection: preferred requester wins a collision.
  always_comb begin
    grant_dm_s = 1'b0;
    if (dm_elig_s && if_elig_s) begin
      grant_dm_s = (rr_q == OWN_DM);
    end else begin
      grant_dm_s = dm_elig_s;
    end
  end

  // Pointer moves to the other requester on every grant.
  always_comb begin
    rr_d = rr_q;
    if ((state_q == ST_IDLE) && grant_any_s) begin
      rr_d = grant_dm_s ? OWN_IF : OWN_DM;
    end else begin
      rr_d = rr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      rr_q <= OWN_DM;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Fixed priority: the data access belongs to the older instruction.
  assign grant_dm_s = dm_elig_s;
`endif

  // Access sequencer next-state and datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_d  = ST_ISSUE;
          mem_en_d = 1'b1;
          owner_d  = grant_dm_s ? OWN_DM : OWN_IF;
          if (grant_dm_s) begin
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = {DATA_W{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_DM) begin
            dm_done_d = 1'b1;
            // A store leaves the load-data register untouched.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any in-flight access.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      owner_q     <= OWN_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_rdata_q  <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;

  // Stalls drop in the done cycle itself, with no registered delay.
  assign if_stall = if_req & ~if_done_q;
  assign dm_stall = dm_req & ~dm_done_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_unified_mem_arbiter
//
// Directed, table-driven bench for unified_mem_arbiter (default build, fixed
// DM-over-IF priority, MEM_LAT=2). A small memory model returns data only in
// the cycle MEM_LAT after mem_en, so wrong latency shows up as bad data.
// -----------------------------------------------------------------------------
module tb_unified_mem_arbiter;

  localparam int LAT = 2;

  logic        CLK;
  logic        Reset_L;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_done;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: 0x40 holds an instruction, other words are address-tagged.
  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C01_0004;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory model: data valid only in the cycle LAT after the mem_en cycle.
  int rd_cnt = 0;
  always @(posedge CLK) begin
    if (mem_en) rd_cnt <= LAT;
    else if (rd_cnt > 0) rd_cnt <= rd_cnt - 1;
  end
  assign mem_rdata = (rd_cnt == 1) ? rdata_of(mem_addr) : 32'hBAD0_BAD0;

  task automatic chk(input int cyc, input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL c%0d %s: got %h expected %h", cyc, nm, act, exp_v);
    end
  endtask

  task automatic chkb(input int cyc, input string nm, input logic act, input logic exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL c%0d %s: got %b expected %b", cyc, nm, act, exp_v);
    end
  endtask

  typedef struct {
    logic        ifr;  logic [31:0] ia;
    logic        dr;   logic dwe; logic [31:0] da; logic [31:0] dw;
    logic        en;   logic we;
    logic        achk; logic [31:0] ma;
    logic        wchk; logic [31:0] mw;
    logic        ifd;  logic dmd; logic ifs; logic dms;
    logic [31:0] ird;  logic [31:0] drd;
  } vec_t;

  function automatic vec_t mk(
    input logic ifr, input logic [31:0] ia, input logic dr, input logic dwe,
    input logic [31:0] da, input logic [31:0] dw, input logic en, input logic we,
    input logic achk, input logic [31:0] ma, input logic wchk, input logic [31:0] mw,
    input logic ifd, input logic dmd, input logic ifs, input logic dms,
    input logic [31:0] ird, input logic [31:0] drd);
    vec_t v;
    v.ifr = ifr; v.ia = ia; v.dr = dr; v.dwe = dwe; v.da = da; v.dw = dw;
    v.en = en; v.we = we; v.achk = achk; v.ma = ma; v.wchk = wchk; v.mw = mw;
    v.ifd = ifd; v.dmd = dmd; v.ifs = ifs; v.dms = dms; v.ird = ird; v.drd = drd;
    return v;
  endfunction

  vec_t tbl[28];

  initial begin
    logic [31:0] r40;
    logic [31:0] r80;
    logic [31:0] r200;
    logic [31:0] r300;
    logic [31:0] z;
    r40  = 32'h8C01_0004;
    r80  = 32'hA5A5_0080;
    r200 = 32'hA5A5_0200;
    r300 = 32'hA5A5_0300;
    z    = 32'h0;

    //            ifr  ia      dr  we  da       dw            en  we  ac ma      wc mw            ifd dmd ifs dms ird   drd
    // fetch 0x40, held through its done cycle, then dropped (stale mask)
    tbl[0]  = mk(1'b1, 32'h40, 1'b0,1'b0,z,     z,            1'b0,1'b0,1'b1,z,     1'b0,z,        1'b0,1'b0,1'b1,1'b0,z,   z);
    tbl[1]  = mk(1'b1, 32'h40, 1'b0,1'b0,z,     z,            1'b1,1'b0,1'b1,32'h40,1'b0,z,        1'b0,1'b0,1'b1,1'b0,z,   z);
    tbl[2]  = mk(1'b1, 32'h40, 1'b0,1'b0,z,     z,            1'b0,1'b0,1'b1,32'h40,1'b0,z,        1'b0,1'b0,1'b1,1'b0,z,   z);
    tbl[3]  = mk(1'b1, 32'h40, 1'b0,1'b0,z,     z,            1'b0,1'b0,1'b1,32'h40,1'b0,z,        1'b0,1'b0,1'b1,1'b0,z,   z);
    tbl[4]  = mk(1'b1, 32'h40, 1'b0,1'b0,z,     z,            1'b0,1'b0,1'b1,32'h40,1'b0,z,        1'b1,1'b0,1'b0,1'b0,r40, z);
    tbl[5]  = mk(1'b0, z,      1'b0,1'b0,z,     z,            1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b0,1'b0,1'b0,r40, z);
    tbl[6]  = mk(1'b0, z,      1'b0,1'b0,z,     z,            1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b0,1'b0,1'b0,r40, z);
    // store 0xDEADBEEF to 0x100
    tbl[7]  = mk(1'b0, z,      1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b0,1'b0,1'b1,r40, z);
    tbl[8]  = mk(1'b0, z,      1'b1,1'b1,32'h100,32'hDEADBEEF,1'b1,1'b1,1'b1,32'h100,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b1,r40, z);
    tbl[9]  = mk(1'b0, z,      1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,1'b0,1'b1,32'h100,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b1,r40, z);
    tbl[10] = mk(1'b0, z,      1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,1'b0,1'b1,32'h100,1'b1,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b1,r40, z);
    tbl[11] = mk(1'b0, z,      1'b1,1'b1,32'h100,32'hDEADBEEF,1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b1,1'b0,1'b0,r40, z);
    tbl[12] = mk(1'b0, z,      1'b0,1'b0,z,     z,            1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b0,1'b0,1'b0,r40, z);
    // collision: fetch 0x80 and load 0x200 together, DM first
    tbl[13] = mk(1'b1, 32'h80, 1'b1,1'b0,32'h200,z,           1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b0,1'b1,1'b1,r40, z);
    tbl[14] = mk(1'b1, 32'h80, 1'b1,1'b0,32'h200,z,           1'b1,1'b0,1'b1,32'h200,1'b0,z,       1'b0,1'b0,1'b1,1'b1,r40, z);
    tbl[15] = mk(1'b1, 32'h80, 1'b1,1'b0,32'h200,z,           1'b0,1'b0,1'b1,32'h200,1'b0,z,       1'b0,1'b0,1'b1,1'b1,r40, z);
    tbl[16] = mk(1'b1, 32'h80, 1'b1,1'b0,32'h200,z,           1'b0,1'b0,1'b1,32'h200,1'b0,z,       1'b0,1'b0,1'b1,1'b1,r40, z);
    tbl[17] = mk(1'b1, 32'h80, 1'b1,1'b0,32'h200,z,           1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b1,1'b1,1'b0,r40, r200);
    tbl[18] = mk(1'b1, 32'h80, 1'b0,1'b0,z,     z,            1'b1,1'b0,1'b1,32'h80,1'b0,z,        1'b0,1'b0,1'b1,1'b0,r40, r200);
    tbl[19] = mk(1'b1, 32'h80, 1'b0,1'b0,z,     z,            1'b0,1'b0,1'b1,32'h80,1'b0,z,        1'b0,1'b0,1'b1,1'b0,r40, r200);
    tbl[20] = mk(1'b1, 32'h80, 1'b0,1'b0,z,     z,            1'b0,1'b0,1'b1,32'h80,1'b0,z,        1'b0,1'b0,1'b1,1'b0,r40, r200);
    tbl[21] = mk(1'b1, 32'h80, 1'b0,1'b0,z,     z,            1'b0,1'b0,1'b0,z,     1'b0,z,        1'b1,1'b0,1'b0,1'b0,r80, r200);
    // store after a load: dm_rdata must keep the loaded word
    tbl[22] = mk(1'b0, z,      1'b1,1'b1,32'h104,32'h12345678,1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b0,1'b0,1'b1,r80, r200);
    tbl[23] = mk(1'b0, z,      1'b1,1'b1,32'h104,32'h12345678,1'b1,1'b1,1'b1,32'h104,1'b1,32'h12345678,1'b0,1'b0,1'b0,1'b1,r80, r200);
    tbl[24] = mk(1'b0, z,      1'b1,1'b1,32'h104,32'h12345678,1'b0,1'b0,1'b1,32'h104,1'b1,32'h12345678,1'b0,1'b0,1'b0,1'b1,r80, r200);
    tbl[25] = mk(1'b0, z,      1'b1,1'b1,32'h104,32'h12345678,1'b0,1'b0,1'b1,32'h104,1'b1,32'h12345678,1'b0,1'b0,1'b0,1'b1,r80, r200);
    tbl[26] = mk(1'b0, z,      1'b1,1'b1,32'h104,32'h12345678,1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b1,1'b0,1'b0,r80, r200);
    tbl[27] = mk(1'b0, z,      1'b0,1'b0,z,     z,            1'b0,1'b0,1'b0,z,     1'b0,z,        1'b0,1'b0,1'b0,1'b0,r80, r200);

    // Reset and check reset values
    Reset_L = 1'b0; if_req = 1'b0; if_addr = z;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = z; dm_wdata = z;
    repeat (3) @(posedge CLK);
    #1;
    chkb(-1, "rst mem_en", mem_en, 1'b0);
    chkb(-1, "rst mem_we", mem_we, 1'b0);
    chk (-1, "rst mem_addr", mem_addr, z);
    chk (-1, "rst mem_wdata", mem_wdata, z);
    chk (-1, "rst if_rdata", if_rdata, z);
    chk (-1, "rst dm_rdata", dm_rdata, z);
    chkb(-1, "rst if_done", if_done, 1'b0);
    chkb(-1, "rst dm_done", dm_done, 1'b0);
    @(negedge CLK);
    Reset_L = 1'b1;
    @(posedge CLK);
    #1;

    // Table-driven cycles
    for (int i = 0; i < 28; i++) begin
      if_req = tbl[i].ifr; if_addr = tbl[i].ia;
      dm_req = tbl[i].dr;  dm_we = tbl[i].dwe; dm_addr = tbl[i].da; dm_wdata = tbl[i].dw;
      @(negedge CLK);
      chkb(i, "mem_en", mem_en, tbl[i].en);
      chkb(i, "mem_en&we", mem_en & mem_we, tbl[i].en & tbl[i].we);
      if (tbl[i].achk) chk(i, "mem_addr", mem_addr, tbl[i].ma);
      if (tbl[i].wchk) begin
        chk (i, "mem_wdata", mem_wdata, tbl[i].mw);
        chkb(i, "mem_we held", mem_we, 1'b1);
      end
      chkb(i, "if_done", if_done, tbl[i].ifd);
      chkb(i, "dm_done", dm_done, tbl[i].dmd);
      chkb(i, "if_stall", if_stall, tbl[i].ifs);
      chkb(i, "dm_stall", dm_stall, tbl[i].dms);
      chk (i, "if_rdata", if_rdata, tbl[i].ird);
      chk (i, "dm_rdata", dm_rdata, tbl[i].drd);
      @(posedge CLK);
      #1;
    end

    // Reset mid-access: fetch 0x300 interrupted during WAIT
    if_req = 1'b1; if_addr = 32'h300;
    @(posedge CLK); #1;
    chkb(100, "ra mem_en", mem_en, 1'b1);
    chk (100, "ra mem_addr", mem_addr, 32'h300);
    @(posedge CLK); #1;
    Reset_L = 1'b0;
    #1;
    chkb(101, "ra rst mem_en", mem_en, 1'b0);
    chk (101, "ra rst mem_addr", mem_addr, z);
    chkb(101, "ra rst if_stall", if_stall, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      chkb(102 + k, "ra no done", if_done, 1'b0);
      chkb(102 + k, "ra no mem_en", mem_en, 1'b0);
      chk (102 + k, "ra if_rdata", if_rdata, z);
    end
    @(negedge CLK);
    Reset_L = 1'b1;
    @(posedge CLK); #1;
    chkb(110, "ra reissue mem_en", mem_en, 1'b1);
    chk (110, "ra reissue addr", mem_addr, 32'h300);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge CLK); #1;
      if (k <= LAT) begin
        chkb(110 + k, "ra wait if_done", if_done, 1'b0);
        chkb(110 + k, "ra wait if_stall", if_stall, 1'b1);
      end else begin
        chkb(110 + k, "ra if_done", if_done, 1'b1);
        chk (110 + k, "ra if_rdata", if_rdata, r300);
        chkb(110 + k, "ra if_stall", if_stall, 1'b0);
      end
    end
    if_req = 1'b0;
    @(posedge CLK); #1;
    chkb(120, "ra after mem_en", mem_en, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
